// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for the 5-stage pipeline.
// Resolves load-use hazards, taken-branch flushes, multi-cycle MDU operations
// held in EX and data-memory wait states (with a timeout watchdog). The hold
// and bubble controls are combinational so they act in the cycle they are
// raised; status outputs (mdu_busy, mem_err, stall_cnt) are registered.
module pipe_hazard_ctrl #(
  parameter int MDU_LAT     = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rt,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic             flush_wb,
  output logic             mdu_busy,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  // The MDU down-counter only ever holds MDU_LAT-1 down to 1.
  localparam int MDU_CW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
  // The wait counter must be able to reach MEM_TIMEOUT itself.
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [MDU_CW-1:0] MDU_LOAD  = MDU_CW'(MDU_LAT - 1);
  localparam logic [MDU_CW-1:0] MDU_ONE   = MDU_CW'(1);
  localparam logic [MDU_CW-1:0] MDU_ZERO  = {MDU_CW{1'b0}};
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = {WAIT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MDU_DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [MDU_CW-1:0] mdu_cnt_r;
  logic [WAIT_W-1:0] wcnt_r;
  logic              mdu_busy_r;
  logic              mem_err_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  logic              mem_pending_s;
  logic              mem_stall_s;
  logic              mem_timeout_s;
  logic              mdu_stall_s;
  logic              load_use_s;

  // Hazard conditions derived from the pipeline inputs and current state.
  always_comb begin
    mem_pending_s = mem_req & ~mem_ready;
    mem_stall_s   = mem_pending_s & (wcnt_r != WAIT_MAX);
    mem_timeout_s = mem_pending_s & (wcnt_r == WAIT_MAX);
    // A new mul/div stalls in the very cycle it shows up in EX; in MDU_DONE
    // the same instruction is still sitting in EX, so mdu_start is ignored.
    if (state_r == ST_MDU_BUSY) begin
      mdu_stall_s = 1'b1;
    end else if (state_r == ST_RUN) begin
      mdu_stall_s = mdu_start;
    end else begin
      mdu_stall_s = 1'b0;
    end
    // Register 0 is hardwired, so a load into $zero never creates a hazard.
    load_use_s = ex_mem_read & (ex_rt != 5'd0) &
                 ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
  end

  // Prioritised stall/flush drive: memory wait, MDU, branch, load-use.
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;
    flush_wb  = 1'b0;
    if (!reset) begin
      stall_if = 1'b0;
    end else if (mem_stall_s) begin
      // Whole pipe freezes; a bubble enters WB while MEM waits.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
      flush_wb  = 1'b1;
    end else if (mdu_stall_s) begin
      // Front end and EX hold; MEM drains and receives a bubble.
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      flush_mem = 1'b1;
    end else if (branch_taken) begin
      // Wrong-path IF and ID instructions are squashed; any load-use on the
      // squashed ID instruction is therefore moot.
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (load_use_s) begin
      // Hold the dependent instruction one cycle and send a bubble to EX.
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      stall_if = 1'b0;
    end
  end

  // MDU sequencing FSM with its down-counter and registered busy flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_RUN;
      mdu_cnt_r  <= MDU_ZERO;
      mdu_busy_r <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (mdu_start) begin
            state_r    <= ST_MDU_BUSY;
            mdu_cnt_r  <= MDU_LOAD;
            mdu_busy_r <= 1'b1;
          end else begin
            mdu_busy_r <= 1'b0;
          end
        end
        ST_MDU_BUSY: begin
          // Counts regardless of memory stalls: the unit keeps computing.
          mdu_cnt_r  <= mdu_cnt_r - MDU_ONE;
          mdu_busy_r <= 1'b1;
          if (mdu_cnt_r == MDU_ONE) begin
            state_r <= ST_MDU_DONE;
          end else begin
            state_r <= ST_MDU_BUSY;
          end
        end
        ST_MDU_DONE: begin
          // Leave only once EX can actually advance past the mul/div.
          if (!mem_stall_s) begin
            state_r    <= ST_RUN;
            mdu_busy_r <= 1'b0;
          end else begin
            mdu_busy_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_RUN;
          mdu_cnt_r  <= MDU_ZERO;
          mdu_busy_r <= 1'b0;
        end
      endcase
    end
  end

  // Memory wait counter and sticky watchdog error.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wcnt_r    <= WAIT_ZERO;
      mem_err_r <= 1'b0;
    end else begin
      if (mem_stall_s) begin
        wcnt_r <= wcnt_r + WAIT_ONE;
      end else begin
        wcnt_r <= WAIT_ZERO;
      end
      if (mem_timeout_s) begin
        mem_err_r <= 1'b1;
      end else begin
        mem_err_r <= mem_err_r;
      end
    end
  end

  // Saturating count of cycles in which the front end was held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_r <= CNT_ZERO;
    end else if (stall_if && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign mdu_busy  = mdu_busy_r;
  assign mem_err   = mem_err_r;
  assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus for pipe_hazard_ctrl with a
// cycle-timestamp reference model compared every cycle, plus literal checks.
module tb_pipe_hazard_ctrl;

  localparam int MDU_LAT     = 4;
  localparam int MEM_TIMEOUT = 16;
  localparam int CNT_W       = 5;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rt;
  logic             id_uses_rt, ex_mem_read, branch_taken, mdu_start;
  logic             mem_req, mem_ready;
  logic             stall_if, stall_id, stall_ex, stall_mem;
  logic             flush_id, flush_ex, flush_mem, flush_wb;
  logic             mdu_busy, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  int checks   = 0;
  int failures = 0;

  pipe_hazard_ctrl #(
    .MDU_LAT(MDU_LAT), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mdu_start(mdu_start),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .stall_mem(stall_mem), .flush_id(flush_id), .flush_ex(flush_ex),
    .flush_mem(flush_mem), .flush_wb(flush_wb),
    .mdu_busy(mdu_busy), .mem_err(mem_err), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // MDU tracked as "active from start cycle until release", with the last
  // stalling cycle stored as an absolute cycle number.
  int m_cyc  = 0;
  int m_last = 0;
  int m_wait = 0;
  int m_cnt  = 0;
  bit m_on   = 1'b0;
  bit m_err  = 1'b0;
  bit m_busy = 1'b0;

  // Compare DUT against model at the falling edge, then advance the model.
  always @(negedge clk) begin
    bit         ms, mdu_go, mdu, lu;
    logic [7:0] e, a;
    a = {stall_if, stall_id, stall_ex, stall_mem,
         flush_id, flush_ex, flush_mem, flush_wb};
    check("model_busy", mdu_busy, m_busy);
    check("model_err", mem_err, m_err);
    check("model_cnt", stall_cnt, m_cnt);
    if (!reset) begin
      check("model_reset_ctrl", a, 0);
      m_on = 1'b0; m_err = 1'b0; m_busy = 1'b0; m_wait = 0; m_cnt = 0;
    end else begin
      ms     = mem_req && !mem_ready && (m_wait < MEM_TIMEOUT);
      mdu_go = !m_on && mdu_start;
      mdu    = mdu_go || (m_on && (m_cyc <= m_last));
      lu     = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
      if (ms)                e = 8'b1111_0001;
      else if (mdu)          e = 8'b1110_0010;
      else if (branch_taken) e = 8'b0000_1100;
      else if (lu)           e = 8'b1100_0100;
      else                   e = 8'b0000_0000;
      check("model_ctrl", a, e);
      if (e[7] && (m_cnt < CNT_MAX)) m_cnt++;
      if (ms) m_wait++;
      else begin
        if (mem_req && !mem_ready && (m_wait == MEM_TIMEOUT)) m_err = 1'b1;
        m_wait = 0;
      end
      if (mdu_go) begin
        m_on   = 1'b1;
        m_last = m_cyc + MDU_LAT - 1;
      end else if (m_on && (m_cyc > m_last) && !ms) begin
        m_on = 1'b0;
      end
      m_busy = m_on;
      m_cyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; ex_rt = 5'd0;
    ex_mem_read = 1'b0; branch_taken = 1'b0; mdu_start = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle();
    reset = 1'b0;
    tick(); tick();
    at_neg();
    check("rst_cnt", stall_cnt, 0);
    check("rst_err", mem_err, 0);
    tick();
    reset = 1'b1;

    // 1. load-use on rs, then ex_rt=0, then rt with/without id_uses_rt
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    at_neg();
    check("lu_stall_if", stall_if, 1);
    check("lu_stall_id", stall_id, 1);
    check("lu_flush_ex", flush_ex, 1);
    check("lu_stall_ex", stall_ex, 0);
    tick();
    idle();
    at_neg();
    check("lu_one_cycle", stall_if, 0);
    check("lu_cnt", stall_cnt, 1);
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
    at_neg();
    check("lu_zero_reg", stall_if, 0);
    tick();
    ex_rt = 5'd9; id_rt = 5'd9; id_rs = 5'd1; id_uses_rt = 1'b0;
    at_neg();
    check("lu_rt_unused", stall_if, 0);
    tick();
    id_uses_rt = 1'b1;
    at_neg();
    check("lu_rt_used", stall_id, 1);
    tick();
    idle();

    // 2. MDU: 4 stall cycles, release with mdu_start still high
    tick();
    mdu_start = 1'b1;
    at_neg();
    check("mdu_s0_stall_ex", stall_ex, 1);
    check("mdu_s0_flush_mem", flush_mem, 1);
    check("mdu_s0_busy", mdu_busy, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      at_neg();
      check("mdu_stall_ex", stall_ex, 1);
      check("mdu_busy_on", mdu_busy, 1);
    end
    tick();
    at_neg();
    check("mdu_release_ex", stall_ex, 0);
    check("mdu_release_fm", flush_mem, 0);
    check("mdu_busy_s4", mdu_busy, 1);
    tick();
    mdu_start = 1'b0;
    at_neg();
    check("mdu_busy_off", mdu_busy, 0);
    check("mdu_cnt", stall_cnt, 6);

    // 3. branch with simultaneous load-use
    tick();
    branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    at_neg();
    check("br_flush_id", flush_id, 1);
    check("br_flush_ex", flush_ex, 1);
    check("br_stall_if", stall_if, 0);
    check("br_stall_id", stall_id, 0);
    tick();
    idle();

    // 4. three wait cycles with a branch held under the stall
    tick();
    mem_req = 1'b1; mem_ready = 1'b0; branch_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check("mw_stall_mem", stall_mem, 1);
      check("mw_flush_wb", flush_wb, 1);
      check("mw_no_flush_id", flush_id, 0);
      tick();
    end
    mem_ready = 1'b1;
    at_neg();
    check("mw_release", stall_mem, 0);
    check("mw_branch_late", flush_id, 1);
    check("mw_no_err", mem_err, 0);
    tick();
    idle();

    // 5. watchdog timeout
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      at_neg();
      check("to_stall_mem", stall_mem, 1);
      tick();
    end
    at_neg();
    check("to_release", stall_mem, 0);
    check("to_err_not_yet", mem_err, 0);
    tick();
    mem_req = 1'b0;
    at_neg();
    check("to_err_set", mem_err, 1);
    tick(); tick(); tick();
    at_neg();
    check("to_err_sticky", mem_err, 1);

    // 6a. memory stall while the MDU sits in its done state
    tick();
    mdu_start = 1'b1;
    tick();
    mdu_start = 1'b0;
    tick();
    mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    at_neg();
    check("md_busy_s4", mdu_busy, 1);
    check("md_stall_mem", stall_mem, 1);
    tick();
    at_neg();
    check("md_busy_s5", mdu_busy, 1);
    tick();
    mem_ready = 1'b1;
    at_neg();
    check("md_free_ex", stall_ex, 0);
    check("md_busy_s6", mdu_busy, 1);
    tick();
    mem_req = 1'b0;
    at_neg();
    check("md_busy_off", mdu_busy, 0);

    // 6b. reset in the middle of an MDU operation with memory pending
    tick();
    mdu_start = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    at_neg();
    check("rs_stall_if", stall_if, 0);
    check("rs_stall_mem", stall_mem, 0);
    tick();
    at_neg();
    check("rs_busy", mdu_busy, 0);
    check("rs_err", mem_err, 0);
    check("rs_cnt", stall_cnt, 0);
    tick();
    idle();
    reset = 1'b1;
    at_neg();
    check("rs_after_stall", stall_if, 0);

    // stall counter saturation
    tick();
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd3;
    repeat (35) tick();
    at_neg();
    check("sat_cnt", stall_cnt, CNT_MAX);
    tick();
    idle();
    tick();
    at_neg();
    check("sat_hold", stall_cnt, CNT_MAX);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage MIPS pipeline.
- Drives the per-stage hold (stall_*) and bubble (flush_*) inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. A register loads when its stall input is 0.
- Handles four cases: load-use hazards, taken-branch flushes, multi-cycle MDU operations in EX, and data-memory wait states with a timeout watchdog.
- Also keeps a saturating stall-cycle performance counter.

Parameters:
- MDU_LAT, 4: total EX stall cycles for a mul/div. Must be >= 2.
- MEM_TIMEOUT, 16: consecutive memory-wait cycles before the watchdog fires.
- CNT_W, 16: width of stall_cnt.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- id_rs  in  5  rs of the instruction in ID
- id_rt  in  5  rt of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_rt  in  5  destination of the load in EX
- ex_mem_read  in  1  EX instruction is a load
- branch_taken  in  1  branch/jump resolved taken in EX
- mdu_start  in  1  EX instruction is a mul/div
- mem_req  in  1  MEM stage accessing data memory
- mem_ready  in  1  data memory completes this cycle
- stall_if  out  1  hold PC / IF-ID register
- stall_id  out  1  hold ID/EX register input side (ID instruction)
- stall_ex  out  1  hold EX/MEM register input side (EX instruction)
- stall_mem  out  1  hold MEM/WB register input side (MEM instruction)
- flush_id  out  1  bubble into IF/ID
- flush_ex  out  1  bubble into ID/EX
- flush_mem  out  1  bubble into EX/MEM
- flush_wb  out  1  bubble into MEM/WB
- mdu_busy  out  1  registered; FSM not in RUN
- mem_err  out  1  registered, sticky; watchdog fired
- stall_cnt  out  CNT_W  registered; cycles with stall_if=1, saturating

Behaviour:
Reset
- While reset=0: FSM goes to RUN, mdu counter=0, wait counter=0, mem_err=0, stall_cnt=0, mdu_busy=0.
- All stall_*/flush_* are forced 0. Reset mid-MDU or mid-wait abandons the operation.

Timing
- stall_*/flush_* are combinational from the inputs plus registered state, so they act in the same cycle.

FSM states: RUN, MDU_BUSY, MDU_DONE; cnt is the internal MDU down-counter.
- RUN with mdu_start=1: MDU stall this cycle; cnt<=MDU_LAT-1; go to MDU_BUSY.
- MDU_BUSY: MDU stall every cycle; cnt decrements; when cnt==1, go to MDU_DONE.
- Total MDU stall is MDU_LAT cycles. The counter runs even under a mem stall.
- MDU_DONE: no MDU stall; mdu_start is ignored (same instruction still in EX); go to RUN on the first cycle with mem_stall=0, otherwise stay.

Memory wait
- mem_stall = mem_req & ~mem_ready & (wcnt != MEM_TIMEOUT).
- wcnt increments on each mem_stall cycle and clears when mem_stall is not asserted.
- When wcnt==MEM_TIMEOUT with the request still pending: mem_err<=1 (sticky until reset), stall releases that cycle, wcnt clears.

Conditions
- load_use = ex_mem_read & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).

Output priority (highest first; lower items apply only if no higher item is active)
1. mem_stall: stall_if/id/ex/mem=1, flush_wb=1.
2. MDU stall: stall_if/id/ex=1, flush_mem=1.
3. branch_taken (in RUN or MDU_DONE): flush_id=1, flush_ex=1. Any simultaneous load_use is suppressed, since the dependent instruction is flushed.
4. load_use: stall_if=1, stall_id=1, flush_ex=1. One cycle only; the load advances to MEM next cycle.

Other rules
- A branch_taken held while stalled by mem_stall is acted on in the first unstalled cycle.
- stall_cnt increments on every cycle with stall_if=1 and saturates at all-ones.

Test Plan:
1. Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 for 1 cycle -> stall_if=stall_id=flush_ex=1 that cycle only; stall_cnt=1. With ex_rt=0 -> no stall.
2. MDU, MDU_LAT=4: mdu_start pulse at cycle S held in EX -> stall_if/id/ex=1 and flush_mem=1 for S..S+3; release at S+4 with mdu_start still 1 and no restart; mdu_busy=1 at S+1..S+4.
3. Branch plus load-use in the same cycle -> flush_id=flush_ex=1, stall_if=0, stall_id=0.
4. Memory wait: mem_req=1, mem_ready low for 3 cycles -> stall_if..stall_mem=1 and flush_wb=1 for 3 cycles; mem_err stays 0.
5. Timeout, MEM_TIMEOUT=16: mem_ready held low -> stall for 16 cycles, release on cycle 17, mem_err=1 persists until reset.
6. Mem stall during MDU_DONE, then reset asserted mid-MDU_BUSY -> FSM waits in MDU_DONE until mem_ready; reset returns all outputs to 0 and state to RUN.
